tt_mux_sel_ctrl: RTL and testbench

TT_MUX_SEL_CTRL -- requirements
Module: tt_mux_sel_ctrl

---
 rtl/tt_mux_sel_ctrl.sv | 110 +++++++++++
 tb/tb_tt_mux_sel_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tt_mux_sel_ctrl.sv
// Project-select mux controller: holds the selected project address and sequences
// enable, clock gate and user reset on the way into and out of a running project.
module tt_mux_sel_ctrl #(
   parameter int ADDR_W     = 9,
   parameter int NUM_PROJ   = 512,
   parameter int RST_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sel_inc,
   input  logic              sel_clr,
   input  logic              sel_ena,
   output logic [ADDR_W-1:0] addr,
   output logic              ena,
   output logic              clk_en,
   output logic              u_rst_n,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_OFF, S_ENA, S_RST, S_RUN, S_STOP_RST, S_STOP_CLK
   } state_t;

   localparam logic [7:0] CNT_LOAD = 8'(RST_CYCLES - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              pend_inc_q, pend_inc_d;
   logic              pend_clr_q, pend_clr_d;
   logic [3:0]        out_q, out_d;

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      if (a == ADDR_W'(NUM_PROJ - 1)) return '0;
      return a + ADDR_W'(1);
   endfunction

   // Output tuple {ena, clk_en, u_rst_n, busy} for a given state.
   function automatic logic [3:0] decode(input state_t s);
      case (s)
         S_ENA:      return 4'b1001;
         S_RST:      return 4'b1101;
         S_RUN:      return 4'b1110;
         S_STOP_RST: return 4'b1101;
         S_STOP_CLK: return 4'b1001;
         default:    return 4'b0000;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      pend_inc_d = pend_inc_q;
      pend_clr_d = pend_clr_q;
      case (state_q)
         S_OFF: begin
            if (sel_clr)      addr_d  = '0;
            else if (sel_inc) addr_d  = next_addr(addr_q);
            else if (sel_ena) state_d = S_ENA;
         end
         S_ENA: begin
            state_d = S_RST;
            cnt_d   = CNT_LOAD;
         end
         S_RST: begin
            if (cnt_q == 8'd0) state_d = S_RUN;
            else               cnt_d   = cnt_q - 8'd1;
         end
         S_RUN: begin
            // Address must not move while the project is live; defer the command.
            if (sel_clr)      pend_clr_d = 1'b1;
            else if (sel_inc) pend_inc_d = 1'b1;
            if (!sel_ena || sel_inc || sel_clr) state_d = S_STOP_RST;
         end
         S_STOP_RST: state_d = S_STOP_CLK;
         S_STOP_CLK: begin
            state_d = S_OFF;
            if (pend_clr_q)      addr_d = '0;
            else if (pend_inc_q) addr_d = next_addr(addr_q);
            pend_inc_d = 1'b0;
            pend_clr_d = 1'b0;
         end
         default: state_d = S_OFF;
      endcase
      out_d = decode(state_d);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_OFF;
         addr_q     <= '0;
         cnt_q      <= 8'd0;
         pend_inc_q <= 1'b0;
         pend_clr_q <= 1'b0;
         out_q      <= 4'b0000;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         pend_inc_q <= pend_inc_d;
         pend_clr_q <= pend_clr_d;
         out_q      <= out_d;
      end
   end

   assign addr                         = addr_q;
   assign {ena, clk_en, u_rst_n, busy} = out_q;

endmodule

// File: tb/tb_tt_mux_sel_ctrl.sv
// Bench for tt_mux_sel_ctrl: directed vector table, wrap sequence, then a long
// random run against a behavioural model, all through an expected-value queue.
module tb_tt_mux_sel_ctrl;

   localparam int RST_CYCLES = 4;
   localparam int NUM_PROJ   = 512;
   localparam logic [3:0] O_OFF = 4'b0000, O_ENA = 4'b1001, O_RST = 4'b1101, O_RUN = 4'b1110;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0, sel_inc = 1'b0, sel_clr = 1'b0, sel_ena = 1'b0;
   logic [8:0] addr;
   logic       ena, clk_en, u_rst_n, busy;

   tt_mux_sel_ctrl #(.ADDR_W(9), .NUM_PROJ(NUM_PROJ), .RST_CYCLES(RST_CYCLES)) dut (
      .clk(clk), .rst_n(rst_n), .sel_inc(sel_inc), .sel_clr(sel_clr), .sel_ena(sel_ena),
      .addr(addr), .ena(ena), .clk_en(clk_en), .u_rst_n(u_rst_n), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         rep;
      logic       r, i, c, e;
      logic [8:0] addr;
      logic [3:0] outs;
   } vec_t;

   typedef struct {
      logic [8:0] addr;
      logic [3:0] outs;
      string      name;
   } exp_t;

   vec_t tbl[$];
   exp_t sbq[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Behavioural reference: 0 OFF, 1 ENA, 2 RST, 3 RUN, 4 STOP_RST, 5 STOP_CLK.
   int ms = 0, maddr = 0, mleft = 0, mpend = 0;

   function automatic void model_step(input logic r, i, c, e);
      if (!r) begin
         ms = 0; maddr = 0; mleft = 0; mpend = 0;
      end else begin
         case (ms)
            0: if (c) maddr = 0; else if (i) maddr = (maddr + 1) % NUM_PROJ; else if (e) ms = 1;
            1: begin ms = 2; mleft = RST_CYCLES; end
            2: begin mleft--; if (mleft == 0) ms = 3; end
            3: begin
               if (c) mpend = 2; else if (i) mpend = 1;
               if (!e || i || c) ms = 4;
            end
            4: ms = 5;
            default: begin
               if (mpend == 2) maddr = 0; else if (mpend == 1) maddr = (maddr + 1) % NUM_PROJ;
               mpend = 0; ms = 0;
            end
         endcase
      end
   endfunction

   function automatic logic [3:0] model_outs();
      case (ms)
         1, 5:    return O_ENA;
         2, 4:    return O_RST;
         3:       return O_RUN;
         default: return O_OFF;
      endcase
   endfunction

   function automatic void add(input int rep, input logic r, i, c, e, input int a, input logic [3:0] o);
      vec_t v;
      v.rep = rep; v.r = r; v.i = i; v.c = c; v.e = e; v.addr = 9'(a); v.outs = o;
      tbl.push_back(v);
   endfunction

   task automatic step(input logic r, i, c, e, input logic [8:0] ea, input logic [3:0] eo, input string nm);
      exp_t x;
      logic [3:0] o;
      @(negedge clk);
      rst_n = r; sel_inc = i; sel_clr = c; sel_ena = e;
      x.addr = ea; x.outs = eo; x.name = nm;
      sbq.push_back(x);
      @(posedge clk);
      #1;
      x = sbq.pop_front();
      o = {ena, clk_en, u_rst_n, busy};
      n_tests++;
      if ({addr, o} !== {x.addr, x.outs}) begin
         n_fail++;
         $display("FAIL %s: got addr=%0d outs=%b, expected addr=%0d outs=%b", x.name, addr, o, x.addr, x.outs);
      end
      n_tests++;
      if ((!ena && (clk_en || u_rst_n)) || (!clk_en && u_rst_n)) begin
         n_fail++;
         $display("FAIL invariant(%s): got outs=%b, expected ena/clk_en gating of u_rst_n", x.name, o);
      end
      n_tests++;
      if (!(o inside {O_OFF, O_ENA, O_RST, O_RUN})) begin
         n_fail++;
         $display("FAIL legal(%s): got outs=%b, expected one of 0000/1001/1101/1110", x.name, o);
      end
   endtask

   initial begin
      logic r, i, c, e;
      // Startup, RUN exit via sel_ena drop, OFF increments.
      add(1, 0,0,0,0, 0, O_OFF);
      add(1, 1,0,0,1, 0, O_ENA);
      add(4, 1,0,0,1, 0, O_RST);
      add(3, 1,0,0,1, 0, O_RUN);
      add(1, 1,0,0,0, 0, O_RST);
      add(1, 1,0,0,0, 0, O_ENA);
      add(1, 1,0,0,0, 0, O_OFF);
      for (int k = 1; k <= 4; k++) add(1, 1,1,0,0, k, O_OFF);
      add(1, 1,1,0,1, 5, O_OFF);
      // Commands ignored in ENA and RST, then select-while-running at addr 5.
      add(1, 1,0,0,1, 5, O_ENA);
      add(1, 1,1,0,1, 5, O_RST);
      add(1, 1,1,0,1, 5, O_RST);
      add(2, 1,0,0,1, 5, O_RST);
      add(1, 1,0,0,1, 5, O_RUN);
      add(1, 1,1,0,1, 5, O_RST);
      add(1, 1,0,0,1, 5, O_ENA);
      add(1, 1,0,0,1, 6, O_OFF);
      add(1, 1,0,0,1, 6, O_ENA);
      add(4, 1,0,0,1, 6, O_RST);
      add(1, 1,0,0,1, 6, O_RUN);
      // Simultaneous inc+clr in RUN: clear wins when applied.
      add(1, 1,1,1,1, 6, O_RST);
      add(1, 1,0,0,1, 6, O_ENA);
      add(1, 1,0,0,0, 0, O_OFF);
      for (int k = 1; k <= 7; k++) add(1, 1,1,0,0, k, O_OFF);
      add(1, 1,1,1,1, 0, O_OFF);
      for (int k = 1; k <= 3; k++) add(1, 1,1,0,0, k, O_OFF);
      // Reset in the middle of RST, then reset while running.
      add(1, 1,0,0,1, 3, O_ENA);
      add(2, 1,0,0,1, 3, O_RST);
      add(1, 0,0,0,1, 0, O_OFF);
      add(1, 1,0,0,1, 0, O_ENA);
      add(4, 1,0,0,1, 0, O_RST);
      add(1, 1,0,0,1, 0, O_RUN);
      add(1, 0,0,0,1, 0, O_OFF);

      foreach (tbl[k])
         for (int n = 0; n < tbl[k].rep; n++)
            step(tbl[k].r, tbl[k].i, tbl[k].c, tbl[k].e, tbl[k].addr, tbl[k].outs, $sformatf("vec%0d", k));

      // Full address walk and wrap from the last project to 0.
      step(0, 0, 0, 0, 9'd0, O_OFF, "wrap_rst");
      for (int k = 1; k < NUM_PROJ; k++) step(1, 1, 0, 0, 9'(k), O_OFF, "walk");
      step(1, 1, 0, 0, 9'd0, O_OFF, "wrap");

      // Random stimulus against the reference model.
      model_step(0, 0, 0, 0);
      step(0, 0, 0, 0, 9'(maddr), model_outs(), "rnd_rst");
      e = 1'b1;
      for (int k = 0; k < 10000; k++) begin
         r = ($urandom_range(0, 99) != 0);
         i = ($urandom_range(0, 9) == 0);
         c = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 15) == 0) e = ~e;
         model_step(r, i, c, e);
         step(r, i, c, e, 9'(maddr), model_outs(), "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
